// File: rtl/tick_divider_ctrl.sv
// Programmable clock-enable generator: one-cycle tick plus near-50% square enable.
// Ratio updates take effect only at period boundaries; stops always land on a wrap.
module tick_divider_ctrl #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic             tick_out,
  output logic             sq_out,
  output logic             busy_out,
  output logic [CNT_W-1:0] div_active
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] div_n;
  logic [CNT_W-1:0] pend_div, pend_n;
  logic             pend_valid, pend_v_n;
  logic             tick_n, sq_n, ready_n, done_n, err_n, busy_n;
  logic             xfer, wrap, half;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      div_active <= CNT_W'(DEFAULT_DIV);
      pend_div   <= '0;
      pend_valid <= 1'b0;
      tick_out   <= 1'b0;
      sq_out     <= 1'b0;
      cfg_ready  <= 1'b1;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
      busy_out   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      div_active <= div_n;
      pend_div   <= pend_n;
      pend_valid <= pend_v_n;
      tick_out   <= tick_n;
      sq_out     <= sq_n;
      cfg_ready  <= ready_n;
      cfg_done   <= done_n;
      cfg_err    <= err_n;
      busy_out   <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    div_n    = div_active;
    pend_n   = pend_div;
    pend_v_n = pend_valid;
    tick_n   = 1'b0;
    sq_n     = sq_out;
    ready_n  = cfg_ready;
    done_n   = 1'b0;
    err_n    = 1'b0;
    xfer     = cfg_valid && cfg_ready;
    wrap     = (cnt == div_active - CNT_W'(1));
    half     = (div_active > CNT_W'(1)) && (cnt == (div_active >> 1) - CNT_W'(1));

    case (state)
      IDLE: begin
        cnt_n = '0;
        sq_n  = 1'b0;
        // A ratio captured on the stopping wrap edge is drained here so cfg_ready cannot stick low.
        if (pend_valid) begin
          div_n    = pend_div;
          pend_v_n = 1'b0;
          done_n   = 1'b1;
          ready_n  = 1'b1;
        end else if (xfer) begin
          if (cfg_div == '0) begin
            err_n = 1'b1;
          end else begin
            div_n  = cfg_div;
            done_n = 1'b1;
          end
        end
        if (enable) state_n = RUN;
      end
      RUN: begin
        if (wrap) begin
          cnt_n  = '0;
          tick_n = 1'b1;
          sq_n   = 1'b1;
          if (pend_valid) begin
            div_n    = pend_div;
            pend_v_n = 1'b0;
            done_n   = 1'b1;
            ready_n  = 1'b1;
          end
          if (!enable) begin
            state_n = IDLE;
            sq_n    = 1'b0;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
          if (half) sq_n = 1'b0;
        end
        // Only reachable with nothing pending, so a wrap-edge transfer waits for the next wrap.
        if (xfer) begin
          if (cfg_div == '0) begin
            err_n = 1'b1;
          end else begin
            pend_n   = cfg_div;
            pend_v_n = 1'b1;
            ready_n  = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == RUN);
  end

endmodule

// File: doc/tick_divider_ctrl.md
Name: tick_divider_ctrl

Overview:
- Run-time programmable clock-enable generator and controller for the graphics pixel and timing domains.
- Produces a one-cycle tick and a near-50% square enable at a divide ratio loaded over a valid/ready config port.
- Ratio changes are applied only at period boundaries, so downstream timing logic never sees a runt period.
- Start and stop are sequenced so the block always stops on a completed period.

Parameters:
- CNT_W, 8: width of the counter and of the divide ratio; legal ratio 1..2^CNT_W-1.
- DEFAULT_DIV, 8: divide ratio loaded at reset; must be 1..2^CNT_W-1.

Ports:
- clk_in, in, 1: the only clock; all logic on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- enable, in, 1: run request; level-sensitive.
- cfg_valid, in, 1: new ratio offered.
- cfg_div, in, CNT_W: offered ratio.
- cfg_ready, out, 1: block can accept a ratio.
- cfg_done, out, 1: one-cycle pulse; the new ratio is now active.
- cfg_err, out, 1: one-cycle pulse; the offered ratio was 0 and was discarded.
- tick_out, out, 1: one-cycle enable, once per period.
- sq_out, out, 1: square enable.
- busy_out, out, 1: high while the state is RUN.
- div_active, out, CNT_W: ratio currently in force.

Behaviour:
- Reset (synchronous, highest priority, also mid-operation):
  - state=IDLE, cnt=0, div_active=DEFAULT_DIV, pending cleared.
  - tick_out=0, sq_out=0, cfg_ready=1, cfg_done=0, cfg_err=0, busy_out=0.
  - An in-flight pending ratio is discarded and no cfg_done is issued.
- States: IDLE and RUN. busy_out is registered and equals (state==RUN).
- IDLE:
  - cnt holds 0; tick_out and sq_out are 0.
  - If enable=1 at an edge, go to RUN with cnt=0.
- RUN, each edge:
  - If cnt==div_active-1 (wrap): cnt<=0, tick_out<=1, sq_out<=1.
  - Else: cnt<=cnt+1, tick_out<=0.
  - If no wrap, div_active>=2 and cnt==(div_active>>1)-1: sq_out<=0. Wrap takes priority over this clear.
- Resulting timing:
  - The first tick is high on the cycle after the div_active-th edge in RUN, and the period is div_active cycles.
  - div=1: tick_out and sq_out stay high continuously.
  - Even div: sq_out is high div/2 cycles. Odd div: high floor(div/2) cycles, low the rest.
- Stop: if enable=0 at a wrap edge in RUN:
  - The final tick is emitted (tick_out<=1), state<=IDLE, cnt<=0, sq_out<=0.
  - If enable returns to 1 before the wrap edge, the stop is cancelled.
- Config handshake: a transfer occurs when cfg_valid and cfg_ready are both 1 at an edge.
  - cfg_div==0: transfer completes, value discarded, cfg_err=1 on the next cycle, div_active unchanged, cfg_ready stays 1.
  - IDLE: div_active<=cfg_div at the transfer edge; cfg_done=1 the next cycle; cfg_ready stays 1.
  - RUN: value goes to pending and cfg_ready<=0. At the next wrap edge: div_active<=pending, cfg_done<=1, cfg_ready<=1. The period in progress finishes at the old ratio.
  - A transfer on the same edge as a wrap goes to pending and is applied at the following wrap, not the current one.
  - A pending ratio is applied at the stop wrap edge too.
- cnt never exceeds div_active-1. The compare uses the div_active value registered before the edge.

Test Plan:
- Reset, then enable=1 with DEFAULT_DIV=8 -> first tick_out 8 edges after entering RUN, then every 8 cycles; sq_out high 4, low 4; busy_out=1.
- In IDLE send cfg_div=5, then enable -> cfg_done one cycle after transfer, div_active=5; tick every 5 cycles; sq_out high 2, low 3.
- In RUN at div=8, send cfg_div=3 at cnt=2 -> cfg_ready low until wrap; current period is still 8 cycles; cfg_done at the wrap; subsequent ticks every 3 cycles.
- Send cfg_div=0 -> cfg_err pulse, div_active unchanged, tick period unchanged; then cfg_div=1 -> tick_out and sq_out continuously high after the boundary.
- Drop enable at cnt=1 with div=6 -> one final tick at the wrap, then IDLE, sq_out=0, busy_out=0. Repeat, re-raising enable before the wrap -> no stop.
- Assert reset mid-period with a pending ratio -> all outputs at reset values next cycle, div_active=DEFAULT_DIV, no cfg_done.
